// File: rtl/uart_pkg.sv
// Constants and helpers shared by the UART receive-side blocks.
package uart_pkg;

  localparam int ERR_CNT_WIDTH = 8;
  localparam logic [ERR_CNT_WIDTH-1:0] ERR_CNT_MAX = 8'd255;

  // Error counters stick at ERR_CNT_MAX instead of wrapping back to zero.
  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] value);
    return (value == ERR_CNT_MAX) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-facing and consumer-facing handshake signals of the receive FIFO.
interface uart_rx_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  rx_data_valid;
  logic [DATA_WIDTH-1:0] rx_parallel_data;
  logic                  rx_parity_error;
  logic                  rx_frame_error;
  logic                  rd_ready;
  logic                  rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  // master: receiver plus consumer environment; slave: the FIFO itself
  modport master (
    output rx_data_valid, rx_parallel_data, rx_parity_error, rx_frame_error, rd_ready,
    input  rd_valid, rd_data
  );

  modport slave (
    input  rx_data_valid, rx_parallel_data, rx_parity_error, rx_frame_error, rd_ready,
    output rd_valid, rd_data
  );
endinterface

// File: rtl/rising_edge_detect.sv
// One-cycle pulse on a 0->1 transition. The previous sample resets to 1 so an
// input that is already high when reset releases does not fire.
module rising_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (reset) prev <= 1'b1;
    else       prev <= din;
  end

  assign pulse = din & ~prev;

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive FIFO with overrun flag and saturating
// parity/frame error counters, fed by the UART receiver.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  uart_rx_fifo_if.slave            bus,
  input  logic                     clear_status,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic                     overrun,
  output logic [ERR_CNT_WIDTH-1:0] parity_err_count,
  output logic [ERR_CNT_WIDTH-1:0] frame_err_count
);

  localparam int ADDR_WIDTH = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic wr_evt;
  logic par_evt;
  logic frm_evt;
  logic rd_fire;
  logic wr_ok;
  logic wr_reject;

  rising_edge_detect u_dv_edge (
    .clk   (clk),
    .reset (reset),
    .din   (bus.rx_data_valid),
    .pulse (wr_evt)
  );

  rising_edge_detect u_par_edge (
    .clk   (clk),
    .reset (reset),
    .din   (bus.rx_parity_error),
    .pulse (par_evt)
  );

  rising_edge_detect u_frm_edge (
    .clk   (clk),
    .reset (reset),
    .din   (bus.rx_frame_error),
    .pulse (frm_evt)
  );

  assign full         = (level == FULL_LEVEL);
  assign empty        = (level == '0);
  assign bus.rd_valid = ~empty;
  assign bus.rd_data  = bus.rd_valid ? mem[rd_ptr] : '0;

  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign rd_fire   = bus.rd_valid & bus.rd_ready;
  assign wr_ok     = wr_evt & (~full | rd_fire);
  assign wr_reject = wr_evt & ~wr_ok;

  // Storage carries no reset; contents are meaningless once the pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= bus.rx_parallel_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_ok)   wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (rd_fire) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      case ({wr_ok, rd_fire})
        2'b10:   level <= level + (ADDR_WIDTH + 1)'(1);
        2'b01:   level <= level - (ADDR_WIDTH + 1)'(1);
        default: level <= level;
      endcase
    end
  end

  // A new event in the clearing cycle wins over clear_status.
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun          <= 1'b0;
      parity_err_count <= '0;
      frame_err_count  <= '0;
    end else begin
      if (wr_reject)         overrun <= 1'b1;
      else if (clear_status) overrun <= 1'b0;

      if (par_evt)
        parity_err_count <= clear_status ? ERR_CNT_WIDTH'(1) : sat_inc(parity_err_count);
      else if (clear_status)
        parity_err_count <= '0;

      if (frm_evt)
        frame_err_count <= clear_status ? ERR_CNT_WIDTH'(1) : sat_inc(frame_err_count);
      else if (clear_status)
        frame_err_count <= '0;
    end
  end

endmodule
